de2i_150_qsys_irq_msg_ctrl: RTL and testbench

Avalon-MM slave interrupt aggregator that sits directly downstream of the Qsys interval timer and the other peripheral `irq` outputs. It captures up to 16 interrupt lines as level or edge events, masks them, and drives a combined `irq`. It also issues one vectored message request per serviced interrupt toward the PCIe bridge over a req/ack handshake. The register interface is 16-bit, has no wait states, and returns registered read data with one cycle of latency.

---
 rtl/de2i_150_qsys_irq_msg_ctrl_if.sv | 21 ++
 rtl/de2i_150_qsys_irq_msg_ctrl.sv | 107 ++++++++++
 tb/tb_de2i_150_qsys_irq_msg_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/de2i_150_qsys_irq_msg_ctrl_if.sv
// Avalon-MM register port plus the message req/ack handshake toward the PCIe bridge.
interface de2i_150_qsys_irq_msg_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        msg_req;
    logic [3:0]  msg_vector;
    logic        msg_ack;

    modport master (
        output address, chipselect, write_n, writedata, msg_ack,
        input  readdata, msg_req, msg_vector
    );

    modport slave (
        input  address, chipselect, write_n, writedata, msg_ack,
        output readdata, msg_req, msg_vector
    );
endinterface

// File: rtl/de2i_150_qsys_irq_msg_ctrl.sv
// Interrupt aggregator: level/edge capture, masking, combined irq and one vectored
// message per serviced source over a req/ack handshake.
module de2i_150_qsys_irq_msg_ctrl #(
    parameter int NUM_IRQ = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    de2i_150_qsys_irq_msg_ctrl_if.slave bus,
    input  logic [NUM_IRQ-1:0]          irq_in,
    output logic                        irq
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t             state, state_nx;
    logic [NUM_IRQ-1:0] irq_d, pending, pending_nx, mask, edge_mode, clr;
    logic [1:0]         ctrl;
    logic [3:0]         vector, vector_nx, enc;
    logic [15:0]        active16;
    logic               wr, any;
    logic               unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign clr       = (wr && bus.address == 3'd0) ? bus.writedata[NUM_IRQ-1:0] : '0;
    assign active16  = 16'(pending & mask);
    assign any       = |active16;
    assign irq       = ctrl[0] & any;
    assign unused_wd = &{1'b0, bus.writedata};

    // Edge bits: a rising edge in the same cycle as a W1C wins over the clear.
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_pend
        assign pending_nx[i] = edge_mode[i]
                             ? ((pending[i] & ~clr[i]) | (irq_in[i] & ~irq_d[i]))
                             : irq_in[i];
    end

    always_comb begin
        enc = '0;
        for (int i = 15; i >= 0; i--)
            if (active16[i]) enc = 4'(i);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_d     <= '0;
            pending   <= '0;
            mask      <= '0;
            edge_mode <= '0;
            ctrl      <= '0;
        end else begin
            irq_d   <= irq_in;
            pending <= pending_nx;
            if (wr) begin
                case (bus.address)
                    3'd1:    mask      <= bus.writedata[NUM_IRQ-1:0];
                    3'd2:    edge_mode <= bus.writedata[NUM_IRQ-1:0];
                    3'd3:    ctrl      <= bus.writedata[1:0];
                    default: ;
                endcase
            end
        end
    end

    // Read data is refreshed every cycle; it only matters after a chipselect read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            case (bus.address)
                3'd0:    bus.readdata <= 16'(pending);
                3'd1:    bus.readdata <= 16'(mask);
                3'd2:    bus.readdata <= 16'(edge_mode);
                3'd3:    bus.readdata <= {14'd0, ctrl};
                3'd4:    bus.readdata <= {any, 11'd0, enc};
                3'd5:    bus.readdata <= 16'(irq_in);
                default: bus.readdata <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            vector <= '0;
        end else begin
            state  <= state_nx;
            vector <= vector_nx;
        end
    end

    // HOLD waits for the serviced source to drop so each assertion yields one message.
    always_comb begin
        state_nx  = state;
        vector_nx = vector;
        case (state)
            IDLE: if (ctrl[0] && ctrl[1] && any) begin
                vector_nx = enc;
                state_nx  = REQ;
            end
            REQ:  if (bus.msg_ack) state_nx = HOLD;
            HOLD: if (!active16[vector]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.msg_req    = (state == REQ);
    assign bus.msg_vector = vector;
endmodule

// File: tb/tb_de2i_150_qsys_irq_msg_ctrl.sv
// Directed bench for the interrupt aggregator; read data and message vectors are
// checked against scoreboard queues filled when stimulus is applied.
module tb_de2i_150_qsys_irq_msg_ctrl;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] irq_in;
    logic       irq;
    int         errors = 0;
    int         checks = 0;
    int         lat;
    logic       seen;
    logic [15:0] rd_q[$];
    logic [3:0]  msg_q[$];

    de2i_150_qsys_irq_msg_ctrl_if bus();

    de2i_150_qsys_irq_msg_ctrl #(.NUM_IRQ(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .irq_in  (irq_in),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        rd_q.push_back(exp);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        tick();
        bus.chipselect = 1'b0;
        chk(tag, bus.readdata, rd_q.pop_front());
    endtask

    task automatic wait_msg(input string tag, output int l);
        l = 0;
        while (!bus.msg_req && l < 10) begin
            tick();
            l++;
        end
        chk({tag, "_req"}, 16'(bus.msg_req), 16'd1);
        if (msg_q.size() == 0) chk({tag, "_queue"}, 16'(msg_q.size()), 16'd1);
        else chk({tag, "_vec"}, 16'(bus.msg_vector), 16'(msg_q.pop_front()));
    endtask

    task automatic quiet(input int n, input string tag);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            seen |= bus.msg_req;
        end
        chk(tag, 16'(seen), 16'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        irq_in = '0;
        bus.chipselect = 1'b0;
        bus.write_n = 1'b1;
        bus.address = '0;
        bus.writedata = '0;
        bus.msg_ack = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        chk("rst_irq", 16'(irq), 16'd0);
        chk("rst_req", 16'(bus.msg_req), 16'd0);
        chk("rst_vec", 16'(bus.msg_vector), 16'd0);
        chk("rst_rdata", bus.readdata, 16'd0);

        // level path
        wr(3'd1, 16'h0001);
        wr(3'd3, 16'h0001);
        irq_in = 8'h01;
        chk("lvl_irq_pre", 16'(irq), 16'd0);
        tick();
        chk("lvl_irq_1", 16'(irq), 16'd1);
        rd(3'd0, 16'h0001, "lvl_pend_hi");
        chk("lvl_irq_2", 16'(irq), 16'd1);
        tick();
        chk("lvl_irq_3", 16'(irq), 16'd1);
        irq_in = 8'h00;
        tick();
        chk("lvl_irq_off", 16'(irq), 16'd0);
        rd(3'd0, 16'h0000, "lvl_pend_lo");

        // edge capture and W1C
        wr(3'd2, 16'h0004);
        wr(3'd1, 16'h0004);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        tick();
        tick();
        rd(3'd0, 16'h0004, "edge_sticky");
        chk("edge_irq", 16'(irq), 16'd1);
        wr(3'd0, 16'h0004);
        rd(3'd0, 16'h0000, "edge_w1c");
        chk("edge_irq_clr", 16'(irq), 16'd0);
        irq_in = 8'h04;
        wr(3'd0, 16'h0004);
        irq_in = 8'h00;
        rd(3'd0, 16'h0004, "edge_set_wins");
        wr(3'd0, 16'h0004);
        rd(3'd0, 16'h0000, "edge_w1c_2");
        wr(3'd2, 16'h0000);
        rd(3'd2, 16'h0000, "edge_mode_rd");

        // priority encoder / vector
        wr(3'd1, 16'h00FF);
        rd(3'd1, 16'h00FF, "mask_rd");
        irq_in = 8'h28;
        tick();
        rd(3'd4, 16'h8003, "vec_3");
        irq_in = 8'h20;
        tick();
        rd(3'd4, 16'h8005, "vec_5");
        rd(3'd5, 16'h0020, "raw");
        irq_in = 8'h00;
        tick();
        rd(3'd4, 16'h0000, "vec_none");

        // message handshake with delayed ack
        wr(3'd3, 16'h0003);
        rd(3'd3, 16'h0003, "ctrl_rd");
        msg_q.push_back(4'd5);
        irq_in = 8'h20;
        wait_msg("hs1", lat);
        chk("hs1_lat", 16'(lat), 16'd2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hs1_hold_req", 16'(bus.msg_req), 16'd1);
            chk("hs1_hold_vec", 16'(bus.msg_vector), 16'd5);
        end
        bus.msg_ack = 1'b1;
        tick();
        bus.msg_ack = 1'b0;
        chk("hs1_fall", 16'(bus.msg_req), 16'd0);
        quiet(5, "hs1_no_repeat");
        irq_in = 8'h00;
        tick();
        tick();
        // ack already high on the first REQ edge gives a one-cycle request
        bus.msg_ack = 1'b1;
        msg_q.push_back(4'd5);
        irq_in = 8'h20;
        wait_msg("hs2", lat);
        chk("hs2_lat", 16'(lat), 16'd2);
        tick();
        bus.msg_ack = 1'b0;
        chk("hs2_min_width", 16'(bus.msg_req), 16'd0);
        irq_in = 8'h00;
        tick();
        tick();

        // simultaneous sources, then MSG_EN cleared mid-request
        msg_q.push_back(4'd1);
        msg_q.push_back(4'd6);
        irq_in = 8'h42;
        wait_msg("sim1", lat);
        bus.msg_ack = 1'b1;
        tick();
        bus.msg_ack = 1'b0;
        chk("sim1_fall", 16'(bus.msg_req), 16'd0);
        irq_in = 8'h40;
        wait_msg("sim6", lat);
        wr(3'd3, 16'h0001);
        chk("noabort_req", 16'(bus.msg_req), 16'd1);
        bus.msg_ack = 1'b1;
        tick();
        bus.msg_ack = 1'b0;
        chk("noabort_fall", 16'(bus.msg_req), 16'd0);
        irq_in = 8'h08;
        quiet(6, "msg_en_off");
        chk("msg_en_off_irq", 16'(irq), 16'd1);

        // reset in the middle of REQ
        msg_q.push_back(4'd3);
        wr(3'd3, 16'h0003);
        wait_msg("pre_rst", lat);
        reset_n = 1'b0;
        #1;
        chk("midrst_req", 16'(bus.msg_req), 16'd0);
        chk("midrst_irq", 16'(irq), 16'd0);
        chk("midrst_vec", 16'(bus.msg_vector), 16'd0);
        tick();
        irq_in = 8'h00;
        reset_n = 1'b1;
        for (int a = 0; a < 6; a++) rd(3'(a), 16'h0000, "post_rst_rd");
        chk("post_rst_irq", 16'(irq), 16'd0);

        chk("sb_empty", 16'(rd_q.size() + msg_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
